// File: rtl/adc_avg_filter_pkg.sv
// Shared ADC averaging definitions: default sample width, window depth and
// the FILL/RUN state encoding used by the moving-average filter.
package adc_avg_filter_pkg;

  // Default ADC sample width in bits.
  localparam int ADC_SAMPLE_W   = 12;
  // log2 of the default averaging window (8 samples).
  localparam int AVG_DEPTH_LOG2 = 3;
  // Accumulator width that holds a full window of full-scale samples.
  localparam int AVG_ACC_W      = ADC_SAMPLE_W + AVG_DEPTH_LOG2;

  // Filter FSM states: FILL while the window is incomplete, RUN once full.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } avg_state_e;

endpackage

// File: rtl/adc_avg_filter_ring.sv
// Ring storage for the moving-average window.
// Ports:
//   clk      - system clock
//   we       - write enable (one accepted sample)
//   wr_addr  - slot written on we
//   wr_data  - sample written on we
//   rd_addr  - slot whose current contents appear on rd_data
//   rd_data  - combinational read of the addressed slot (the value about to be
//              overwritten when rd_addr == wr_addr)
// The array has no reset: the filter never uses a slot before writing it.
module adc_avg_ring
  import adc_avg_filter_pkg::*;
#(
  parameter int W  = ADC_SAMPLE_W,
  parameter int AW = AVG_DEPTH_LOG2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_r [0:(1 << AW)-1];

  // Write the accepted sample into its slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average filter over the last 2^DEPTH_LOG2 ADC samples.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset (overrides flush and strobe)
//   sample_in  - ADC sample, valid while sample_stb is high
//   sample_stb - one-cycle sample-ready strobe
//   flush      - discard the window and restart filling
//   avg_out    - registered window average (floor), held between pulses
//   avg_valid  - one-cycle pulse marking a new avg_out
//   filled     - high while the window holds a full set of samples
module adc_avg_filter
  import adc_avg_filter_pkg::*;
#(
  parameter int SAMPLE_W   = ADC_SAMPLE_W,
  parameter int DEPTH_LOG2 = AVG_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_stb,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] avg_out,
  output logic                avg_valid,
  output logic                filled
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACC_W = SAMPLE_W + DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  avg_state_e            state_r;
  avg_state_e            state_s;
  logic [ACC_W-1:0]      acc_r;
  logic [ACC_W-1:0]      acc_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_s;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_s;
  logic                  pend_r;
  logic                  pend_s;
  logic                  accept_s;
  logic [SAMPLE_W-1:0]   old_raw_s;
  logic [SAMPLE_W-1:0]   old_s;
  logic [SAMPLE_W-1:0]   avg_out_r;
  logic                  avg_valid_r;
  logic                  filled_r;

  // The slot about to be overwritten is read at the same address it is written.
  adc_avg_ring #(
    .W  (SAMPLE_W),
    .AW (DEPTH_LOG2)
  ) u_ring (
    .clk     (clk),
    .we      (accept_s),
    .wr_addr (wr_ptr_r),
    .wr_data (sample_in),
    .rd_addr (wr_ptr_r),
    .rd_data (old_raw_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, accumulator, pointer and fill-count logic.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    wr_ptr_s = wr_ptr_r;
    count_s  = count_r;
    pend_s   = 1'b0;
    accept_s = sample_stb & ~flush & ~rst;

    // During FILL the slot holds stale data, so nothing is subtracted.
    if (state_r == ST_RUN) begin
      old_s = old_raw_s;
    end else begin
      old_s = {SAMPLE_W{1'b0}};
    end

    if (flush) begin
      state_s  = ST_FILL;
      acc_s    = {ACC_W{1'b0}};
      wr_ptr_s = {DEPTH_LOG2{1'b0}};
      count_s  = {CNT_W{1'b0}};
    end else if (accept_s) begin
      // acc always equals the window sum, which fits ACC_W bits exactly.
      acc_s    = acc_r + ACC_W'(sample_in) - ACC_W'(old_s);
      wr_ptr_s = wr_ptr_r + DEPTH_LOG2'(1);
      case (state_r)
        ST_FILL: begin
          count_s = count_r + CNT_W'(1);
          if (count_r == CNT_LAST) begin
            state_s = ST_RUN;
            pend_s  = 1'b1;
          end else begin
            state_s = ST_FILL;
          end
        end
        ST_RUN: begin
          state_s = ST_RUN;
          count_s = CNT_FULL;
          pend_s  = 1'b1;
        end
        default: begin
          state_s  = ST_FILL;
          acc_s    = {ACC_W{1'b0}};
          wr_ptr_s = {DEPTH_LOG2{1'b0}};
          count_s  = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      pend_s = 1'b0;
    end
  end

  // Datapath and output registers; the average lags the accept by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {ACC_W{1'b0}};
      wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      pend_r      <= 1'b0;
      avg_out_r   <= {SAMPLE_W{1'b0}};
      avg_valid_r <= 1'b0;
      filled_r    <= 1'b0;
    end else begin
      acc_r       <= acc_s;
      wr_ptr_r    <= wr_ptr_s;
      count_r     <= count_s;
      pend_r      <= pend_s;
      filled_r    <= (state_s == ST_RUN);
      // A flush arriving on the publish edge cancels the pending pulse.
      avg_valid_r <= pend_r & ~flush;
      if (pend_r && !flush) begin
        avg_out_r <= acc_r[ACC_W-1:DEPTH_LOG2];
      end else begin
        avg_out_r <= avg_out_r;
      end
    end
  end

  assign avg_out   = avg_out_r;
  assign avg_valid = avg_valid_r;
  assign filled    = filled_r;

endmodule

// File: tb/tb_adc_avg_filter.sv
module tb_adc_avg_filter;

  localparam int W  = 12;
  localparam int DL = 3;
  localparam int N  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_stb = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic [W-1:0] avg_out;
  logic         avg_valid;
  logic         filled;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the window as a plain queue of the most recent samples.
  int           win[$];
  logic         exp_valid  = 1'b0;
  logic         exp_filled = 1'b0;
  logic [W-1:0] exp_out    = '0;
  logic         pend       = 1'b0;
  logic [W-1:0] pend_val   = '0;

  adc_avg_filter #(.SAMPLE_W(W), .DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .sample_stb (sample_stb),
    .flush      (flush),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .filled     (filled)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic f, input logic s, input logic [W-1:0] d);
    int sum;
    if (r) begin
      win.delete();
      exp_out = '0; exp_valid = 1'b0; exp_filled = 1'b0; pend = 1'b0;
    end else begin
      exp_valid = pend && !f;
      if (pend && !f) exp_out = pend_val;
      pend = 1'b0;
      if (f) begin
        win.delete();
        exp_filled = 1'b0;
      end else if (s) begin
        win.push_back(int'(d));
        if (win.size() > N) win.delete(0);
        if (win.size() == N) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          pend = 1'b1;
          pend_val = W'(sum / N);
        end
        exp_filled = (win.size() == N);
      end
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, settle.
  task automatic step(input logic r, input logic f, input logic s, input logic [W-1:0] d);
    rst = r; flush = f; sample_stb = s; sample_in = d;
    @(posedge clk);
    model_edge(r, f, s, d);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(1)), 1'b1, W'($urandom));
      n_checks++;
      if ({avg_valid, filled, avg_out} !== {1'b0, 1'b0, 12'h000}) begin
        n_fail++;
        $display("FAIL reset_state: got v=%0b f=%0b out=%h, expected v=0 f=0 out=000", avg_valid, filled, avg_out);
      end
    end
  endtask

  task automatic test_fill;
    step(1'b1, 1'b0, 1'b0, 12'h000);
    for (int i = 1; i <= N; i++) begin
      step(1'b0, 1'b0, 1'b1, 12'h800);
      n_checks++;
      if ({avg_valid, filled} !== {1'b0, (i == N) ? 1'b1 : 1'b0}) begin
        n_fail++;
        $display("FAIL fill_strobe%0d: got v=%0b f=%0b, expected v=0 f=%0b", i, avg_valid, filled, (i == N));
      end
    end
    step(1'b0, 1'b0, 1'b0, 12'h000);
    n_checks++;
    if ({avg_valid, filled, avg_out} !== {1'b1, 1'b1, 12'h800}) begin
      n_fail++;
      $display("FAIL fill_pulse: got v=%0b f=%0b out=%h, expected v=1 f=1 out=800", avg_valid, filled, avg_out);
    end
    step(1'b0, 1'b0, 1'b0, 12'h000);
    n_checks++;
    if ({avg_valid, avg_out} !== {1'b0, 12'h800}) begin
      n_fail++;
      $display("FAIL fill_hold: got v=%0b out=%h, expected v=0 out=800", avg_valid, avg_out);
    end
  endtask

  task automatic test_full_scale;
    step(1'b1, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 12'hFFF);
    n_checks++;
    if (dut.acc_r !== 15'h7FF8) begin
      n_fail++;
      $display("FAIL full_scale_acc: got %h, expected 7ff8", dut.acc_r);
    end
    step(1'b0, 1'b0, 1'b0, 12'h000);
    n_checks++;
    if ({avg_valid, avg_out} !== {1'b1, 12'hFFF}) begin
      n_fail++;
      $display("FAIL full_scale_avg: got v=%0b out=%h, expected v=1 out=fff", avg_valid, avg_out);
    end
  endtask

  task automatic test_sliding;
    step(1'b1, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 12'h000);
    n_checks++;
    if (dut.wr_ptr_r !== 3'd0) begin
      n_fail++;
      $display("FAIL sliding_ptr8: got %0d, expected 0", dut.wr_ptr_r);
    end
    step(1'b0, 1'b0, 1'b1, 12'h800);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    n_checks++;
    if ({avg_valid, avg_out} !== {1'b1, 12'h100}) begin
      n_fail++;
      $display("FAIL sliding_first: got v=%0b out=%h, expected v=1 out=100", avg_valid, avg_out);
    end
    for (int i = 0; i < N - 1; i++) begin
      step(1'b0, 1'b0, 1'b1, 12'h800);
      n_checks++;
      if ({avg_valid, filled, avg_out} !== {exp_valid, exp_filled, exp_out}) begin
        n_fail++;
        $display("FAIL sliding_step%0d: got v=%0b f=%0b out=%h, expected v=%0b f=%0b out=%h",
                 i, avg_valid, filled, avg_out, exp_valid, exp_filled, exp_out);
      end
    end
    n_checks++;
    if (dut.wr_ptr_r !== 3'd0) begin
      n_fail++;
      $display("FAIL sliding_ptr16: got %0d, expected 0", dut.wr_ptr_r);
    end
    step(1'b0, 1'b0, 1'b0, 12'h000);
    n_checks++;
    if ({avg_valid, avg_out} !== {1'b1, 12'h800}) begin
      n_fail++;
      $display("FAIL sliding_last: got v=%0b out=%h, expected v=1 out=800", avg_valid, avg_out);
    end
  endtask

  task automatic test_truncation;
    step(1'b1, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, W'(i));
    step(1'b0, 1'b0, 1'b0, 12'h000);
    n_checks++;
    if ({avg_valid, avg_out} !== {1'b1, 12'h003}) begin
      n_fail++;
      $display("FAIL truncation: got v=%0b out=%h, expected v=1 out=003", avg_valid, avg_out);
    end
  endtask

  task automatic test_flush_collision;
    logic [W-1:0] held;
    held = avg_out;
    step(1'b0, 1'b1, 1'b1, 12'hABC);
    n_checks++;
    if ({avg_valid, filled, avg_out} !== {1'b0, 1'b0, held}) begin
      n_fail++;
      $display("FAIL flush_collision: got v=%0b f=%0b out=%h, expected v=0 f=0 out=%h", avg_valid, filled, avg_out, held);
    end
    for (int i = 1; i <= N + 1; i++) begin
      step(1'b0, 1'b0, (i <= N), W'($urandom));
      n_checks++;
      if ({avg_valid, filled, avg_out} !== {exp_valid, exp_filled, exp_out} || avg_valid !== (i == N + 1)) begin
        n_fail++;
        $display("FAIL flush_refill%0d: got v=%0b f=%0b out=%h, expected v=%0b f=%0b out=%h",
                 i, avg_valid, filled, avg_out, (i == N + 1), exp_filled, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    for (int i = 0; i < N + 3; i++) step(1'b0, 1'b0, 1'b1, W'($urandom));
    step(1'b1, 1'b0, 1'b1, 12'h7FF);
    n_checks++;
    if ({avg_valid, filled, avg_out} !== {1'b0, 1'b0, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_mid_run: got v=%0b f=%0b out=%h, expected all 0", avg_valid, filled, avg_out);
    end
    for (int i = 1; i <= N + 1; i++) begin
      step(1'b0, 1'b0, (i <= N), 12'h800);
      n_checks++;
      if ({avg_valid, filled, avg_out} !== {(i == N + 1) ? 1'b1 : 1'b0, (i >= N) ? 1'b1 : 1'b0,
                                            (i == N + 1) ? 12'h800 : 12'h000}) begin
        n_fail++;
        $display("FAIL reset_refill%0d: got v=%0b f=%0b out=%h", i, avg_valid, filled, avg_out);
      end
    end
  endtask

  task automatic test_random;
    logic r, f, s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(99) == 0);
      f = ($urandom_range(99) < 3);
      s = ($urandom_range(99) < 70);
      step(r, f, s, W'($urandom));
      n_checks++;
      if ({avg_valid, filled, avg_out} !== {exp_valid, exp_filled, exp_out}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got v=%0b f=%0b out=%h, expected v=%0b f=%0b out=%h",
                 i, avg_valid, filled, avg_out, exp_valid, exp_filled, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_scale();
    test_sliding();
    test_truncation();
    test_flush_collision();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
ADC_AVG_FILTER -- requirements
Module: adc_avg_filter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose parameter SAMPLE_W, default 12, meaning the ADC sample width.
REQ-003 The block SHALL expose parameter DEPTH_LOG2, default 3, meaning log2 of the averaging window (8 samples).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sample_in  input  SAMPLE_W  12-bit sample from the ADC stage register.
REQ-007 sample_stb  input  1  one-cycle "sample ready" strobe from the ADC stage (its ban pulse); sample_in is valid only while this strobe is high.
REQ-008 flush  input  1  synchronous request to discard the window and restart filling.
REQ-009 avg_out  output  SAMPLE_W  registered moving average of the last 2^DEPTH_LOG2 samples.
REQ-010 avg_valid  output  1  one-cycle pulse marking a new avg_out.
REQ-011 filled  output  1  high while the window holds a full set of samples.

Function
REQ-012 The FSM SHALL have two states: FILL (fewer than 2^DEPTH_LOG2 samples held) and RUN (window full).
- FILL -> RUN: on the accepted strobe that brings the count to 2^DEPTH_LOG2.
- RUN -> FILL: on flush or rst only.
REQ-013 A strobe SHALL be accepted on any cycle where sample_stb=1, rst=0 and flush=0.
- Throughput: one sample per clock; back-to-back strobes are legal.
REQ-014 On accept, sample_in SHALL be written to ring slot wr_ptr, and wr_ptr SHALL increment modulo 2^DEPTH_LOG2.
REQ-015 On accept, acc SHALL become acc + sample_in - old, where old is the slot being overwritten in RUN and 0 in FILL.
- Consequence: the ring storage needs no reset.
REQ-016 acc SHALL be SAMPLE_W+DEPTH_LOG2 bits wide (15 by default) and SHALL never overflow or underflow.
REQ-017 avg_out SHALL be acc shifted right by DEPTH_LOG2 (floor, truncation), registered.
REQ-018 Latency: a strobe accepted at edge E updates acc at E; avg_out and avg_valid SHALL update at edge E+1, so avg_valid is high for exactly the one cycle following E+1.
REQ-019 avg_valid SHALL pulse only for accepted strobes made while in RUN, or for the strobe causing the FILL->RUN transition; no pulse during FILL.
REQ-020 avg_out SHALL hold its value between pulses.
REQ-021 The fill counter SHALL saturate at 2^DEPTH_LOG2.
REQ-022 filled SHALL equal (state==RUN), registered.
REQ-023 flush SHALL clear acc, wr_ptr and the fill count, and move the FSM to FILL on the next edge.
- Flush has priority over a simultaneous sample_stb; that sample is discarded.
- avg_out keeps its last value; avg_valid is 0.
REQ-024 A strobe coinciding with the edge at which flush or rst is sampled SHALL produce no avg_valid pulse.

Reset
REQ-025 On rst=1 at a clock edge:
- state=FILL, acc=0, wr_ptr=0, fill count=0;
- avg_out=0, avg_valid=0, filled=0.
REQ-026 Reset SHALL override flush and sample_stb.
REQ-027 Reset asserted mid-RUN SHALL require a full 2^DEPTH_LOG2 new samples before the next avg_valid.

Structure
REQ-028 The shared ADC package/include SHALL hold ADC_SAMPLE_W=12, AVG_DEPTH_LOG2=3 and the FILL/RUN state encodings.
REQ-029 Ring storage SHALL be a sub-module adc_avg_ring: a write-enabled array with address-indexed read of the old value. Accumulator and FSM stay in the top module.

Verification
REQ-030 Fill: after rst, 8 strobes of 0x800 -> no avg_valid for strobes 1-7; filled rises after strobe 8; avg_valid pulses 2 cycles after strobe 8 with avg_out=0x800.
REQ-031 Full scale: 8 back-to-back strobes of 0xFFF -> acc=0x7FF8, avg_out=0xFFF, no wrap.
REQ-032 Sliding/wrap: 8x0x000, then one 0x800 -> avg_out=0x100; after 7 more 0x800 -> avg_out=0x800; wr_ptr back to 0 after each 8 samples.
REQ-033 Truncation: samples 0,1,2,3,4,5,6,7 -> avg_out=3 (sum 28).
REQ-034 Flush collision: in RUN, flush and sample_stb in the same cycle -> no avg_valid, filled=0 the next cycle, sample ignored, 8 new strobes needed before next pulse.
REQ-035 Reset mid-run: rst pulse during back-to-back strobes -> all outputs 0 the next cycle, strobe in the reset cycle ignored, refill behaves as in REQ-030.
